// File: rtl/arb3_rr_ctrl_pkg.sv
// Shared types and helpers for the three-way round-robin arbiter.
// Index arithmetic is modulo three throughout.
package arb_pkg;

    localparam int N_REQ_C = 3;
    localparam int IDX_W   = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    function automatic logic [IDX_W-1:0] rot_next(input logic [IDX_W-1:0] idx);
        return (idx >= 2'd2) ? 2'd0 : idx + 2'd1;
    endfunction

    function automatic logic [N_REQ_C-1:0] onehot(input logic [IDX_W-1:0] idx);
        return 3'b001 << idx;
    endfunction

endpackage

// File: rtl/arb3_rr_ctrl_if.sv
// Request/grant bundle between the requesters and the arbiter.
// Handshake: req[i] is a level held by requester i for as long as it wants the
// resource; gnt is a registered one-hot answer that appears one cycle after req
// is sampled and stays until the owner drops req or is preempted by timeout.
interface arb3_rr_ctrl_if;
    import arb_pkg::*;

    logic [N_REQ_C-1:0] req;
    logic [N_REQ_C-1:0] gnt;
    logic               gnt_valid;
    logic [IDX_W-1:0]   gnt_id;
    logic               preempt;

    modport master (output req, input gnt, input gnt_valid, input gnt_id, input preempt);
    modport slave  (input req, output gnt, output gnt_valid, output gnt_id, output preempt);

endinterface

// File: rtl/arb3_rr_ctrl_rr_pick.sv
// Combinational round-robin search: first set bit of req & ~excl_mask,
// scanning ptr, ptr+1, ptr+2 (mod 3).
module rr_pick
    import arb_pkg::*;
(
    input  logic [N_REQ_C-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    input  logic [N_REQ_C-1:0] excl_mask,
    output logic               hit,
    output logic [IDX_W-1:0]   win_idx
);

    logic [3:0]       cand;
    logic [IDX_W-1:0] idx;

    always_comb begin
        hit     = 1'b0;
        win_idx = '0;
        // Pad to four bits so every 2-bit index is in range.
        cand    = {1'b0, req & ~excl_mask};
        idx     = ptr;
        for (int k = 0; k < N_REQ_C; k++) begin
            if (!hit && cand[idx]) begin
                hit     = 1'b1;
                win_idx = idx;
            end
            idx = rot_next(idx);
        end
    end

endmodule

// File: rtl/arb3_rr_ctrl.sv
// Round-robin arbiter for three requesters with bounded hold time and
// timeout preemption when another requester is waiting.
module arb3_rr_ctrl
    import arb_pkg::*;
#(
    parameter int N_REQ    = 3,
    parameter int MAX_HOLD = 8,
    parameter int CNT_W    = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    arb3_rr_ctrl_if.slave      bus,
    output state_e             dbg_state,
    output logic [IDX_W-1:0]   dbg_ptr,
    output logic [CNT_W-1:0]   dbg_hold_cnt
);

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

    state_e             state_q, state_d;
    logic [N_REQ-1:0]   gnt_q, gnt_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [IDX_W-1:0]   id_q, id_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               valid_q, preempt_q, preempt_d;
    logic [N_REQ-1:0]   owner_hits;
    logic               hit;
    logic [IDX_W-1:0]   win_idx;

    assign owner_hits = bus.req & gnt_q;

    // Excluding the current owner is needed for preemption and harmless on
    // release, because the owner's req bit is already clear then.
    rr_pick u_pick (
        .req       (bus.req),
        .ptr       (ptr_q),
        .excl_mask (gnt_q),
        .hit       (hit),
        .win_idx   (win_idx)
    );

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        ptr_d     = ptr_q;
        id_d      = id_q;
        cnt_d     = cnt_q;
        preempt_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (hit) begin
                    state_d = GRANT;
                    gnt_d   = onehot(win_idx);
                    id_d    = win_idx;
                    ptr_d   = rot_next(win_idx);
                    cnt_d   = '0;
                end
            end
            GRANT: begin
                if (|owner_hits) begin
                    if (cnt_q < HOLD_LAST) begin
                        cnt_d = cnt_q + 1'b1;
                    end else if (hit) begin
                        gnt_d     = onehot(win_idx);
                        id_d      = win_idx;
                        ptr_d     = rot_next(win_idx);
                        cnt_d     = '0;
                        preempt_d = 1'b1;
                    end
                end else if (hit) begin
                    gnt_d = onehot(win_idx);
                    id_d  = win_idx;
                    ptr_d = rot_next(win_idx);
                    cnt_d = '0;
                end else begin
                    state_d = IDLE;
                    gnt_d   = '0;
                    id_d    = '0;
                    cnt_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            ptr_q     <= '0;
            id_q      <= '0;
            cnt_q     <= '0;
            valid_q   <= 1'b0;
            preempt_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            ptr_q     <= ptr_d;
            id_q      <= id_d;
            cnt_q     <= cnt_d;
            valid_q   <= |gnt_d;
            preempt_q <= preempt_d;
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.gnt_valid = valid_q;
    assign bus.gnt_id    = id_q;
    assign bus.preempt   = preempt_q;
    assign dbg_state     = state_q;
    assign dbg_ptr       = ptr_q;
    assign dbg_hold_cnt  = cnt_q;

endmodule

// File: tb/tb_arb3_rr_ctrl.sv
// Directed bench for arb3_rr_ctrl: rotation, timeout preemption, saturation,
// release-vs-timeout priority and asynchronous reset.
module tb_arb3_rr_ctrl;
  import arb_pkg::*;

  logic clk;
  logic rst_n;
  state_e dbg_state;
  logic [1:0] dbg_ptr;
  logic [7:0] dbg_hold_cnt;

  int n_checks = 0;
  int n_pass = 0;
  logic [2:0] exp_q[$];

  arb3_rr_ctrl_if bus();

  arb3_rr_ctrl #(.N_REQ(3), .MAX_HOLD(8), .CNT_W(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .dbg_state    (dbg_state),
    .dbg_ptr      (dbg_ptr),
    .dbg_hold_cnt (dbg_hold_cnt)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset();
    bus.req = 3'b000;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // drive req for one edge; returns at the following negedge
  task automatic cyc(input logic [2:0] r);
    bus.req = r;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp)
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else
      n_pass++;
  endtask

  initial begin
    logic [2:0] rot_req [7];
    logic [2:0] e;

    rst_n = 1'b0;
    bus.req = 3'b000;
    @(negedge clk);
    do_reset();

    // reset values
    check("rst_gnt", 32'(bus.gnt), 32'h0);
    check("rst_valid", 32'(bus.gnt_valid), 32'h0);
    check("rst_id", 32'(bus.gnt_id), 32'h0);
    check("rst_preempt", 32'(bus.preempt), 32'h0);
    check("rst_state", 32'(dbg_state), 32'(IDLE));
    check("rst_ptr", 32'(dbg_ptr), 32'h0);

    // single requester grant and release
    cyc(3'b001);
    check("t1_gnt", 32'(bus.gnt), 32'h1);
    check("t1_id", 32'(bus.gnt_id), 32'h0);
    check("t1_valid", 32'(bus.gnt_valid), 32'h1);
    check("t1_ptr", 32'(dbg_ptr), 32'h1);
    cyc(3'b000);
    check("t1_rel_gnt", 32'(bus.gnt), 32'h0);
    check("t1_rel_valid", 32'(bus.gnt_valid), 32'h0);
    check("t1_rel_state", 32'(dbg_state), 32'(IDLE));

    // rotation 0,1,2,0 with each owner leaving after two grant cycles
    do_reset();
    rot_req = '{3'b111, 3'b111, 3'b110, 3'b111, 3'b101, 3'b111, 3'b011};
    exp_q = {3'b001, 3'b001, 3'b010, 3'b010, 3'b100, 3'b100, 3'b001};
    for (int i = 0; i < 7; i++) begin
      cyc(rot_req[i]);
      e = exp_q.pop_front();
      check("rot_gnt", 32'(bus.gnt), 32'(e));
      check("rot_preempt", 32'(bus.preempt), 32'h0);
    end
    check("rot_id", 32'(bus.gnt_id), 32'h0);

    // contended timeout: 011 held constant
    do_reset();
    for (int i = 1; i <= 18; i++) begin
      cyc(3'b011);
      if (i <= 8)       e = 3'b001;
      else if (i <= 16) e = 3'b010;
      else              e = 3'b001;
      check("to_gnt", 32'(bus.gnt), 32'(e));
      check("to_preempt", 32'(bus.preempt), (i == 9 || i == 17) ? 32'h1 : 32'h0);
    end
    check("to_id", 32'(bus.gnt_id), 32'h0);

    // uncontended hold saturates
    do_reset();
    for (int i = 0; i < 20; i++) begin
      cyc(3'b100);
      check("sat_gnt", 32'(bus.gnt), 32'h4);
      check("sat_preempt", 32'(bus.preempt), 32'h0);
    end
    check("sat_cnt", 32'(dbg_hold_cnt), 32'd7);
    check("sat_id", 32'(bus.gnt_id), 32'h2);

    // owner 1 releases in the timeout cycle while 2 waits
    do_reset();
    cyc(3'b010);
    check("rt_gnt0", 32'(bus.gnt), 32'h2);
    for (int i = 0; i < 7; i++) cyc(3'b110);
    check("rt_cnt", 32'(dbg_hold_cnt), 32'd7);
    check("rt_gnt1", 32'(bus.gnt), 32'h2);
    cyc(3'b100);
    check("rt_gnt2", 32'(bus.gnt), 32'h4);
    check("rt_preempt", 32'(bus.preempt), 32'h0);

    // asynchronous reset mid-grant
    do_reset();
    cyc(3'b010);
    cyc(3'b010);
    check("ar_gnt_pre", 32'(bus.gnt), 32'h2);
    #2 rst_n = 1'b0;
    #1;
    check("ar_gnt", 32'(bus.gnt), 32'h0);
    check("ar_valid", 32'(bus.gnt_valid), 32'h0);
    check("ar_id", 32'(bus.gnt_id), 32'h0);
    bus.req = 3'b110;
    @(negedge clk);
    rst_n = 1'b1;
    cyc(3'b110);
    check("ar_first_gnt", 32'(bus.gnt), 32'h2);
    check("ar_first_id", 32'(bus.gnt_id), 32'h1);
    check("ar_first_ptr", 32'(dbg_ptr), 32'h2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
